line_buffer_3row: RTL and testbench
===================================

Name: line_buffer_3row

Overview:
- Producer side of the 3x3 window datapath: turns a single raster pixel stream into three vertically aligned row taps.
- Output row order: dout1 = row r-2, dout2 = row r-1, dout3 = row r.
- Sits between the video source and the 3x3 matrix/convolution stage.
- Stores two previous lines in on-chip RAM and tracks column, row and fill state.

Parameters:
- WIDTH, 24, pixel bit width (RGB888).
- PIC_WIDTH, 480, active pixels per line; valid range 3..511.
- PIC_HEIGHT, 272, active lines per frame; valid range 3..511.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  din carries a pixel this cycle.
- sof_in  input  1  qualified by valid_in; current pixel is row 0, column 0 of a new frame.
- din  input  WIDTH  pixel in raster order.
- valid_out  output  1  dout1..3 hold an aligned column.
- dout1  output  WIDTH  pixel at same column, row r-2.
- dout2  output  WIDTH  pixel at same column, row r-1.
- dout3  output  WIDTH  pixel at current column, row r (delayed din).
- eol_out  output  1  qualified by valid_out; last column of a line.
- eof_out  output  1  qualified by valid_out; last pixel of the frame.

Behaviour:
- Reset values:
  - All outputs 0.
  - col_cnt = 0, row_cnt = 0, state FILL0.
  - RAM contents are not cleared and are don't-care.
- Counters: 9-bit col_cnt/row_cnt, advance only on valid_in.
  - col wraps PIC_WIDTH-1 -> 0 and increments row.
  - row wraps PIC_HEIGHT-1 -> 0.
- sof_in with valid_in:
  - Pixel is treated as col 0, row 0.
  - Next counter values are col 1, row 0; state forced to FILL0.
  - This applies mid-frame, discarding the partial frame with no flush.
- Line storage: two RAMs, ram_a (row r-2) and ram_b (row r-1), depth PIC_WIDTH. For an accepted pixel at column x:
  - Read ram_a[x] and ram_b[x] (old data, read-before-write).
  - Write ram_a[x] <= old ram_b[x] and ram_b[x] <= din.
- Output timing:
  - dout1 = old ram_a[x], dout2 = old ram_b[x], dout3 = din.
  - All are registered and appear exactly 1 clk after the accepting edge.
- FSM, transitions evaluated at the wrap of col_cnt:
  - FILL0 (row 0) -> FILL1.
  - FILL1 (row 1) -> RUN.
  - RUN -> FILL0 at last pixel of row PIC_HEIGHT-1.
- valid_out: 1 clk after valid_in only when the accepted pixel is in RUN; otherwise 0.
  - Each frame yields PIC_HEIGHT-2 output lines of PIC_WIDTH pixels.
- eol_out / eof_out:
  - Registered alongside valid_out.
  - eof_out implies eol_out.
  - Both are 0 whenever valid_out is 0.
- valid_in gaps: all state and outputs hold, except valid_out/eol_out/eof_out, which drop to 0 the cycle after a non-valid cycle.
- Back-to-back frames with no gap are supported; the wrap to row 0 needs no sof_in.
- Reset mid-frame: returns to reset state; the next accepted pixel is treated as row 0 whether or not sof_in is asserted.

Optional Feature:
- Macro: LINE_BUFFER_BORDER_REPLICATE_EN.
- Defined:
  - valid_out also asserts for FILL0 and FILL1 pixels, giving PIC_HEIGHT output lines per frame.
  - FILL0: dout1 = dout2 = dout3 = din.
  - FILL1: dout1 = dout2 = old ram_b[x], dout3 = din.
  - Missing upper rows are replicated from the top edge.
  - eol/eof follow the same rules.
- Undefined: behaviour exactly as in Behaviour.

Decomposition:
- Package line_buffer_pkg holds:
  - The state enum {FILL0, FILL1, RUN}, 2-bit.
  - Default WIDTH/PIC_WIDTH/PIC_HEIGHT constants.
  - The 9-bit counter width constant.
- Sub-module line_ram_sdp:
  - Simple dual-port RAM, parameters DATA_W and DEPTH.
  - Synchronous write, read-before-write at the same address, instantiated twice.
- Top holds the counters, FSM, output registers and the macro-guarded mux.

Test Plan (PIC_WIDTH=4, PIC_HEIGHT=4, pixel value = row*16+col):
- Continuous frame, sof_in on first pixel -> valid_out first asserts 1 clk after pixel 0x20 is accepted, with dout1/2/3 = 0x00/0x10/0x20.
  - 8 valid outputs total.
  - eol_out on 0x23 and 0x33; eof_out only on 0x33.
- Same frame with valid_in toggling 1/0 every cycle -> identical output sequence; valid_out never asserted in a cycle following a valid_in=0 cycle.
- Two frames back-to-back without a second sof_in, second frame values +0x80 -> second frame first output is 0x80/0x90/0xA0; no frame-1 data appears.
- sof_in at pixel 0x12 of frame 1, followed by a full frame -> no valid_out until row 2 of the new frame; first output is 0x00/0x10/0x20 (new frame values).
- rst_n pulsed low asynchronously mid-RUN -> all outputs 0 immediately; after release the next frame behaves as in scenario 1.
- With LINE_BUFFER_BORDER_REPLICATE_EN -> 16 outputs.
  - Pixel 0x01 gives 0x01/0x01/0x01.
  - Pixel 0x11 gives 0x01/0x01/0x11.
  - Pixel 0x21 gives 0x01/0x11/0x21.

Source files
------------

// File: rtl/line_buffer_pkg.sv
// -----------------------------------------------------------------------------
// line_buffer_pkg
// Shared types and default constants for the 3-row line buffer.
//   state_t      : fill/run state of the line buffer (FILL0, FILL1, RUN)
//   CNT_W        : width of the column/row counters
//   DEF_*        : default pixel width and frame geometry
// -----------------------------------------------------------------------------
package line_buffer_pkg;

    localparam int CNT_W          = 9;
    localparam int DEF_WIDTH      = 24;
    localparam int DEF_PIC_WIDTH  = 480;
    localparam int DEF_PIC_HEIGHT = 272;

    typedef enum logic [1:0] {
        FILL0 = 2'd0,   // receiving row 0, no rows stored yet
        FILL1 = 2'd1,   // receiving row 1, one row stored
        RUN   = 2'd2    // two rows stored, full columns available
    } state_t;

endpackage

// File: rtl/line_ram_sdp.sv
// -----------------------------------------------------------------------------
// line_ram_sdp
// Simple dual-port line RAM, one write port and one registered read port on
// the same clock. A read and a write to the same address in the same cycle
// returns the old contents (read-before-write). Contents are never cleared.
// Ports:
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata holds its value while re is low
//   raddr  : read address
//   rdata  : registered read data (valid the cycle after re)
// -----------------------------------------------------------------------------
module line_ram_sdp #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 480,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/line_buffer_3row.sv
// -----------------------------------------------------------------------------
// line_buffer_3row
// Turns a raster pixel stream into three vertically aligned row taps for a
// 3x3 window stage. Two previous lines live in line RAMs; ram_b holds row r-1
// and ram_a holds row r-2. Each accepted pixel shifts its column down one row.
//
// Optional build macro LINE_BUFFER_BORDER_REPLICATE_EN: also emit rows 0 and 1
// with the missing upper rows replicated from the top edge.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   valid_in   : din carries a pixel
//   sof_in     : with valid_in, pixel is row 0 column 0 of a new frame
//   din        : pixel in raster order
//   valid_out  : dout1..3 hold an aligned column
//   dout1      : row r-2, same column
//   dout2      : row r-1, same column
//   dout3      : row r (delayed din)
//   eol_out    : with valid_out, last column of a line
//   eof_out    : with valid_out, last pixel of the frame
// -----------------------------------------------------------------------------
module line_buffer_3row
    import line_buffer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
    parameter int PIC_HEIGHT = DEF_PIC_HEIGHT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             sof_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             eol_out,
    output logic             eof_out
);

    localparam int RAM_AW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(PIC_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(PIC_HEIGHT - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] col_cnt_reg, col_cnt_next;
    logic [CNT_W-1:0] row_cnt_reg, row_cnt_next;

    // Position and state of the pixel presented this cycle, after sof override
    state_t           pix_state;
    logic [CNT_W-1:0] pix_col;
    logic [CNT_W-1:0] pix_row;
    logic             last_col;
    logic             last_row;
    logic             emit;
    logic [RAM_AW-1:0] ram_addr;

    logic             valid_out_reg;
    logic             eol_out_reg;
    logic             eof_out_reg;
    logic [WIDTH-1:0] din_reg;
    logic             blank_reg;      // outputs forced to 0 until the first pixel after reset
    logic             a_wr_pend_reg;  // ram_a shift write pending from previous accept
    logic [RAM_AW-1:0] a_wr_addr_reg;

    logic [WIDTH-1:0] ram_a_q;
    logic [WIDTH-1:0] ram_b_q;
    logic [WIDTH-1:0] row_a_sel;
    logic [WIDTH-1:0] row_b_sel;

`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
    state_t           pix_state_reg;
`endif

    // -------------------------------------------------------------------------
    // Next-state: counters and FSM advance only on accepted pixels
    // -------------------------------------------------------------------------
    always_comb begin
        pix_state = state_reg;
        pix_col   = col_cnt_reg;
        pix_row   = row_cnt_reg;
        if (valid_in && sof_in) begin
            pix_state = FILL0;
            pix_col   = '0;
            pix_row   = '0;
        end

        last_col = (pix_col == LAST_COL);
        last_row = (pix_row == LAST_ROW);

        state_next   = state_reg;
        col_cnt_next = col_cnt_reg;
        row_cnt_next = row_cnt_reg;

        if (valid_in) begin
            state_next   = pix_state;
            row_cnt_next = pix_row;
            col_cnt_next = last_col ? '0 : pix_col + CNT_W'(1);
            if (last_col) begin
                row_cnt_next = last_row ? '0 : pix_row + CNT_W'(1);
                case (pix_state)
                    FILL0:   state_next = FILL1;
                    FILL1:   state_next = RUN;
                    RUN:     state_next = last_row ? FILL0 : RUN;
                    default: state_next = FILL0;
                endcase
            end
        end

`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
        emit = 1'b1;
`else
        emit = (pix_state == RUN);
`endif

        ram_addr = pix_col[RAM_AW-1:0];
    end

    // -------------------------------------------------------------------------
    // State, counters and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= FILL0;
            col_cnt_reg   <= '0;
            row_cnt_reg   <= '0;
            valid_out_reg <= 1'b0;
            eol_out_reg   <= 1'b0;
            eof_out_reg   <= 1'b0;
            din_reg       <= '0;
            blank_reg     <= 1'b1;
            a_wr_pend_reg <= 1'b0;
`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
            pix_state_reg <= FILL0;
`endif
        end else begin
            state_reg     <= state_next;
            col_cnt_reg   <= col_cnt_next;
            row_cnt_reg   <= row_cnt_next;
            valid_out_reg <= valid_in && emit;
            eol_out_reg   <= valid_in && emit && last_col;
            eof_out_reg   <= valid_in && emit && last_col && last_row;
            a_wr_pend_reg <= valid_in;
            if (valid_in) begin
                din_reg   <= din;
                blank_reg <= 1'b0;
`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
                pix_state_reg <= pix_state;
`endif
            end
        end
    end

    // The old ram_b word only appears on the read port after the accepting
    // edge, so it is copied into ram_a one cycle later at the same column.
    // The next access to that column is at least one line away.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            a_wr_addr_reg <= ram_addr;
        end
    end

    line_ram_sdp #(
        .DATA_W (WIDTH),
        .DEPTH  (PIC_WIDTH),
        .ADDR_W (RAM_AW)
    ) u_ram_a (
        .clk   (clk),
        .we    (a_wr_pend_reg),
        .waddr (a_wr_addr_reg),
        .wdata (ram_b_q),
        .re    (valid_in),
        .raddr (ram_addr),
        .rdata (ram_a_q)
    );

    line_ram_sdp #(
        .DATA_W (WIDTH),
        .DEPTH  (PIC_WIDTH),
        .ADDR_W (RAM_AW)
    ) u_ram_b (
        .clk   (clk),
        .we    (valid_in),
        .waddr (ram_addr),
        .wdata (din),
        .re    (valid_in),
        .raddr (ram_addr),
        .rdata (ram_b_q)
    );

    // -------------------------------------------------------------------------
    // Output selection (pure mux of registered values)
    // -------------------------------------------------------------------------
    always_comb begin
        row_a_sel = ram_a_q;
        row_b_sel = ram_b_q;
`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
        case (pix_state_reg)
            FILL0: begin
                row_a_sel = din_reg;
                row_b_sel = din_reg;
            end
            FILL1: begin
                row_a_sel = ram_b_q;
            end
            default: begin
            end
        endcase
`endif
        dout1 = blank_reg ? '0 : row_a_sel;
        dout2 = blank_reg ? '0 : row_b_sel;
        dout3 = blank_reg ? '0 : din_reg;
    end

    assign valid_out = valid_out_reg;
    assign eol_out   = eol_out_reg;
    assign eof_out   = eof_out_reg;

endmodule

// File: tb/tb_line_buffer_3row.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_3row
// Scoreboard bench for line_buffer_3row with a 4x4 frame, pixel = row*16+col.
// Stimulus tasks push expected columns; a monitor pops on valid_out.
// -----------------------------------------------------------------------------
module tb_line_buffer_3row;

    localparam int W = 24;
`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif
    localparam int FRAME_OUTS = BORDER ? 16 : 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         valid_in = 1'b0;
    logic         sof_in = 1'b0;
    logic [W-1:0] din = '0;
    logic         valid_out;
    logic [W-1:0] dout1, dout2, dout3;
    logic         eol_out, eof_out;

    typedef struct packed {
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [W-1:0] d3;
        logic         eol;
        logic         eof;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_got;
    int   checks  = 0;
    int   errors  = 0;
    int   out_cnt = 0;
    logic vin_q   = 1'b0;

    always #5 clk = ~clk;

    line_buffer_3row #(
        .WIDTH      (W),
        .PIC_WIDTH  (4),
        .PIC_HEIGHT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .sof_in    (sof_in),
        .din       (din),
        .valid_out (valid_out),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3),
        .eol_out   (eol_out),
        .eof_out   (eof_out)
    );

    // valid_in as seen at the last rising edge
    always @(posedge clk) vin_q <= valid_in;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_out) begin
                out_cnt++;
                checks++;
                mon_got = '{d1: dout1, d2: dout2, d3: dout3, eol: eol_out, eof: eof_out};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got %h/%h/%h eol=%b eof=%b required none",
                             dout1, dout2, dout3, eol_out, eof_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_got !== mon_e) begin
                        errors++;
                        $display("FAIL out_%0d got %h/%h/%h eol=%b eof=%b required %h/%h/%h eol=%b eof=%b",
                                 out_cnt, dout1, dout2, dout3, eol_out, eof_out,
                                 mon_e.d1, mon_e.d2, mon_e.d3, mon_e.eol, mon_e.eof);
                    end else begin
                        $display("OUT %0d %h/%h/%h eol=%b eof=%b ok", out_cnt,
                                 dout1, dout2, dout3, eol_out, eof_out);
                    end
                end
            end else begin
                checks++;
                if (eol_out || eof_out) begin
                    errors++;
                    $display("FAIL flags_without_valid got eol=%b eof=%b required 0/0", eol_out, eof_out);
                end
            end
            if (!vin_q) begin
                checks++;
                if (valid_out) begin
                    errors++;
                    $display("FAIL valid_after_gap got valid_out=1 required 0");
                end
            end
        end
    end

    // Drive one pixel of logical row r / column c; push its expected column
    task automatic pix(input int base, input int r, input int c, input bit sof, input bit gap);
        exp_t e;
        bit   push;
        @(posedge clk);
        #2;
        valid_in = 1'b1;
        sof_in   = sof;
        din      = W'(base + r * 16 + c);
        push     = 1'b1;
        e.eol    = (c == 3);
        e.eof    = (c == 3) && (r == 3);
        if (r >= 2) begin
            e.d1 = W'(base + (r - 2) * 16 + c);
            e.d2 = W'(base + (r - 1) * 16 + c);
            e.d3 = W'(base + r * 16 + c);
        end else if (r == 1) begin
            e.d1 = W'(base + c);
            e.d2 = W'(base + c);
            e.d3 = W'(base + 16 + c);
            push = BORDER;
        end else begin
            e.d1 = W'(base + c);
            e.d2 = W'(base + c);
            e.d3 = W'(base + c);
            push = BORDER;
        end
        if (push) exp_q.push_back(e);
        if (gap) begin
            @(posedge clk);
            #2;
            valid_in = 1'b0;
            sof_in   = 1'b0;
        end
    endtask

    task automatic frame(input int base, input bit sof, input bit gap);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pix(base, r, c, sof && (r == 0) && (c == 0), gap);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #2;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Bounded drain: every expected column must have appeared
    task automatic end_scenario(input string name, input int exp_n);
        idle(4);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got %0d outstanding required 0", name, exp_q.size());
        end
        checks++;
        if (out_cnt != exp_n) begin
            errors++;
            $display("FAIL %s_count got %0d outputs required %0d", name, out_cnt, exp_n);
        end
        $display("SCENARIO %s done, %0d outputs", name, out_cnt);
        out_cnt = 0;
        exp_q.delete();
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({valid_out, eol_out, eof_out, dout1, dout2, dout3} !== '0) begin
            errors++;
            $display("FAIL %s got v=%b eol=%b eof=%b %h/%h/%h required all 0",
                     name, valid_out, eol_out, eof_out, dout1, dout2, dout3);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        #2 rst_n = 1'b1;

        // 1: continuous frame with sof
        frame(0, 1'b1, 1'b0);
        end_scenario("continuous", FRAME_OUTS);

        // 2: valid_in toggling every cycle
        frame(0, 1'b1, 1'b1);
        end_scenario("toggle", FRAME_OUTS);

        // 3: back-to-back frames, second without sof, values +0x80
        frame(0, 1'b1, 1'b0);
        frame(8'h80, 1'b0, 1'b0);
        end_scenario("back2back", 2 * FRAME_OUTS);

        // 4: partial frame up to 0x11, then sof restarts with a full frame
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                if (r == 0 || c < 2) pix(0, r, c, (r == 0) && (c == 0), 1'b0);
        frame(0, 1'b1, 1'b0);
        end_scenario("sof_restart", FRAME_OUTS + (BORDER ? 6 : 0));

        // 5: async reset mid-RUN, then a frame without sof
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                if (r < 2 || c < 2) pix(0, r, c, (r == 0) && (c == 0), 1'b0);
        end_scenario("pre_reset", BORDER ? 10 : 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        frame(0, 1'b0, 1'b0);
        end_scenario("after_reset", FRAME_OUTS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no completion required finish before 100000ns");
        $fatal(1, "timeout");
    end

endmodule
